gray_stream_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational 3x3 grayscale stage.
- Converts N packed RGB pixels per beat to gray in a 2-stage valid/ready pipeline.
- Four output modes: bypass, gray, binary threshold, inverted gray.
- Sits between the camera/line-buffer window source and the Sobel core; carries sideband bits (sync/DE) aligned with the pixels.

---
 rtl/gray_stream_pipe.sv | 151 +++++++++++++++
 tb/tb_gray_stream_pipe.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_stream_pipe.sv
// gray_stream_pipe: two-stage valid/ready pipeline converting PIX packed RGB
// pixels per beat to gray, with bypass / gray / threshold / inverted-gray modes.
// Mode and threshold are captured on start-of-frame beats and travel with each
// beat, so a config change never alters a frame already in flight.
//
// Ports:
//   clk, reset_n          pixel clock, async active-low reset
//   cfg_mode, cfg_thresh  requested mode/threshold, sampled on sof beats
//   s_valid/s_ready       input handshake (s_ready is combinational)
//   s_data, s_user, s_sof input pixels, sideband, start-of-frame
//   m_valid/m_ready       output handshake
//   m_data, m_user, m_sof processed pixels with aligned sideband
module gray_stream_pipe #(
  parameter int unsigned PIX    = 9,
  parameter int unsigned CW     = 4,
  parameter int unsigned USER_W = 3,
  parameter int unsigned WR     = 77,
  parameter int unsigned WG     = 154,
  parameter int unsigned WB     = 25
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            cfg_mode,
  input  logic [CW-1:0]         cfg_thresh,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [PIX*3*CW-1:0]   s_data,
  input  logic [USER_W-1:0]     s_user,
  input  logic                  s_sof,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [PIX*3*CW-1:0]   m_data,
  output logic [USER_W-1:0]     m_user,
  output logic                  m_sof
);

  localparam int unsigned PW = 3 * CW;    // bits per pixel
  localparam int unsigned DW = PIX * PW;  // bits per beat
  localparam int unsigned MW = CW + 8;    // product width
  localparam int unsigned SW = CW + 10;   // weighted-sum width
  localparam int unsigned GW = CW + 2;    // sum >> 8 before saturation

  localparam logic [1:0] MODE_BYPASS = 2'd0;
  localparam logic [1:0] MODE_GRAY   = 2'd1;
  localparam logic [1:0] MODE_THRESH = 2'd2;

  // Weights must form a unity-gain 8-bit fixed-point filter.
  if ((WR + WG + WB) != 256 || WR > 255 || WG > 255 || WB > 255) begin : g_bad_weights
    $error("gray_stream_pipe: WR+WG+WB must equal 256 with each weight 8-bit");
  end

  logic                   v1, v2, en1, en2;
  logic [1:0]             active_mode, eff_mode, mode1;
  logic [CW-1:0]          active_thresh, eff_thresh, thresh1;
  logic [DW-1:0]          raw1, out_c;
  logic [USER_W-1:0]      user1;
  logic                   sof1;
  logic [PIX-1:0][MW-1:0] pr_c, pg_c, pb_c, pr1, pg1, pb1;
  logic [PIX-1:0][GW-1:0] gs_c;
  logic [PIX-1:0][CW-1:0] g_c;

  // Handshake: a stage advances when it is empty or the stage after it advances.
  assign en2      = !v2 || m_ready;
  assign en1      = !v1 || en2;
  assign s_ready  = en1;
  assign m_valid  = v2;

  // A sof beat uses the incoming config; other beats use the frame's latched config.
  assign eff_mode   = s_sof ? cfg_mode   : active_mode;
  assign eff_thresh = s_sof ? cfg_thresh : active_thresh;

  // Per-pixel channel products for stage 1.
  always_comb begin
    pr_c = '0;
    pg_c = '0;
    pb_c = '0;
    for (int k = 0; k < PIX; k++) begin
      pr_c[k] = MW'(WR) * MW'(s_data[k*PW + 2*CW +: CW]);
      pg_c[k] = MW'(WG) * MW'(s_data[k*PW + CW +: CW]);
      pb_c[k] = MW'(WB) * MW'(s_data[k*PW +: CW]);
    end
  end

  // Stage 1 registers and frame config latch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1            <= 1'b0;
      pr1           <= '0;
      pg1           <= '0;
      pb1           <= '0;
      raw1          <= '0;
      mode1         <= MODE_GRAY;
      thresh1       <= '0;
      user1         <= '0;
      sof1          <= 1'b0;
      active_mode   <= MODE_GRAY;
      active_thresh <= '0;
    end else if (en1) begin
      v1 <= s_valid;
      if (s_valid) begin
        pr1     <= pr_c;
        pg1     <= pg_c;
        pb1     <= pb_c;
        raw1    <= s_data;
        mode1   <= eff_mode;
        thresh1 <= eff_thresh;
        user1   <= s_user;
        sof1    <= s_sof;
        if (s_sof) begin
          active_mode   <= cfg_mode;
          active_thresh <= cfg_thresh;
        end
      end
    end
  end

  // Stage 2 combinational: rounded gray, saturated, then mode select.
  always_comb begin
    gs_c  = '0;
    g_c   = '0;
    out_c = '0;
    for (int k = 0; k < PIX; k++) begin
      gs_c[k] = GW'((SW'(pr1[k]) + SW'(pg1[k]) + SW'(pb1[k]) + SW'(128)) >> 8);
      g_c[k]  = (|gs_c[k][GW-1:CW]) ? '1 : gs_c[k][CW-1:0];
      case (mode1)
        MODE_BYPASS: out_c[k*PW +: PW] = raw1[k*PW +: PW];
        MODE_GRAY:   out_c[k*PW +: PW] = {3{g_c[k]}};
        MODE_THRESH: out_c[k*PW +: PW] = {PW{g_c[k] >= thresh1}};
        default:     out_c[k*PW +: PW] = {3{~g_c[k]}};
      endcase
    end
  end

  // Stage 2 / output registers; held while stalled or on bubbles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v2     <= 1'b0;
      m_data <= '0;
      m_user <= '0;
      m_sof  <= 1'b0;
    end else if (en2) begin
      v2 <= v1;
      if (v1) begin
        m_data <= out_c;
        m_user <= user1;
        m_sof  <= sof1;
      end
    end
  end

endmodule

// File: tb/tb_gray_stream_pipe.sv
// Self-checking bench for gray_stream_pipe: vector table, directed corner
// sequences and a scoreboard fed at every accepted input beat.
`timescale 1ns/1ps
module tb_gray_stream_pipe;

  localparam int unsigned PIX = 9;
  localparam int unsigned CW  = 4;
  localparam int unsigned UW  = 3;
  localparam int unsigned PW  = 3 * CW;
  localparam int unsigned DW  = PIX * PW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    cfg_mode;
  logic [CW-1:0] cfg_thresh;
  logic          s_valid, s_ready, s_sof;
  logic [DW-1:0] s_data;
  logic [UW-1:0] s_user;
  logic          m_valid, m_ready, m_sof;
  logic [DW-1:0] m_data;
  logic [UW-1:0] m_user;

  gray_stream_pipe #(.PIX(PIX), .CW(CW), .USER_W(UW), .WR(77), .WG(154), .WB(25)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_mode(cfg_mode), .cfg_thresh(cfg_thresh),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_user(s_user), .s_sof(s_sof),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_user(m_user), .m_sof(m_sof)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [3:0]  thresh;
    logic [11:0] pix;
    logic [11:0] exp;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [UW-1:0] user;
    logic          sof;
    int            stamp;
  } sb_t;

  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  inflight = 0;
  int  ndeliv = 0;
  bit  chk_lat = 1'b0;
  bit  rand_ready = 1'b0;
  bit  ready_fix = 1'b1;
  sb_t sbq[$];
  logic [11:0] out_log[$];
  logic [1:0]  act_mode = 2'd1;
  logic [3:0]  act_th = 4'd0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] model_pix(input logic [11:0] p, input logic [1:0] md,
                                            input logic [3:0] th);
    int gy;
    logic [3:0] g4;
    gy = (77 * int'(p[11:8]) + 154 * int'(p[7:4]) + 25 * int'(p[3:0]) + 128) / 256;
    if (gy > 15) gy = 15;
    g4 = 4'(gy);
    case (md)
      2'd0:    return p;
      2'd1:    return {g4, g4, g4};
      2'd2:    return (g4 >= th) ? 12'hFFF : 12'h000;
      default: return {~g4, ~g4, ~g4};
    endcase
  endfunction

  function automatic logic [DW-1:0] model_beat(input logic [DW-1:0] d, input logic [1:0] md,
                                               input logic [3:0] th);
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < PIX; k++) r[k*PW +: PW] = model_pix(d[k*PW +: PW], md, th);
    return r;
  endfunction

  function automatic logic [DW-1:0] rep(input logic [11:0] p);
    return {PIX{p}};
  endfunction

  // Cycle counter for latency checks.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Sole driver of m_ready: fixed level or random backpressure.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fix;
    end
  end

  // Monitor/scoreboard, sampling at the falling edge.
  initial begin
    logic [DW+UW:0] held;
    bit hold_pend;
    sb_t e;
    logic [1:0] em;
    logic [3:0] eth;
    int acc, del;
    hold_pend = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        sbq.delete();
        inflight = 0;
        act_mode = 2'd1;
        act_th = 4'd0;
        hold_pend = 1'b0;
      end else begin
        acc = 0;
        del = 0;
        chk("s_ready", DW'(s_ready), DW'(!(inflight == 2 && !m_ready)));
        if (hold_pend) chk("stall_hold", DW'({m_sof, m_user, m_data}), DW'(held));
        hold_pend = m_valid && !m_ready;
        held = {m_sof, m_user, m_data};
        if (m_valid && m_ready) begin
          del = 1;
          ndeliv++;
          out_log.push_back(m_data[11:0]);
          if (sbq.size() == 0) begin
            chk("unexpected_beat", DW'(1), DW'(0));
          end else begin
            e = sbq.pop_front();
            chk("sb_data", m_data, e.data);
            chk("sb_user_sof", DW'({m_user, m_sof}), DW'({e.user, e.sof}));
            if (chk_lat) chk("latency", DW'(cyc - e.stamp), DW'(2));
          end
        end
        if (s_valid && s_ready) begin
          acc = 1;
          em  = s_sof ? cfg_mode : act_mode;
          eth = s_sof ? cfg_thresh : act_th;
          if (s_sof) begin
            act_mode = cfg_mode;
            act_th = cfg_thresh;
          end
          e.data = model_beat(s_data, em, eth);
          e.user = s_user;
          e.sof = s_sof;
          e.stamp = cyc;
          sbq.push_back(e);
        end
        inflight = inflight + acc - del;
      end
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic [UW-1:0] u, input logic sof,
                      input logic [1:0] md, input logic [3:0] th);
    bit ok;
    s_data = d;
    s_user = u;
    s_sof = sof;
    cfg_mode = md;
    cfg_thresh = th;
    s_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = s_ready;
    end
    chk("send_accept", DW'(ok), DW'(1));
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_sof = 1'b0;
  endtask

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 500 && !done; n++) begin
      @(negedge clk);
      done = (sbq.size() == 0);
    end
    chk(name, DW'(done), DW'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic check_log(input string name, input logic [11:0] e[8], input int n);
    chk({name, "_count"}, DW'(out_log.size()), DW'(n));
    for (int i = 0; i < n; i++) chk(name, DW'(out_log[i]), DW'(e[i]));
  endtask

  initial begin
    vec_t tbl[10];
    logic [11:0] ex[8];
    logic [DW-1:0] d;
    int base;

    tbl[0] = '{2'd1, 4'd0, 12'hFFF, 12'hFFF};
    tbl[1] = '{2'd1, 4'd0, 12'hF00, 12'h555};
    tbl[2] = '{2'd1, 4'd0, 12'h0F0, 12'h999};
    tbl[3] = '{2'd1, 4'd0, 12'h00F, 12'h111};
    tbl[4] = '{2'd2, 4'd6, 12'hF00, 12'h000};
    tbl[5] = '{2'd2, 4'd6, 12'h0F0, 12'hFFF};
    tbl[6] = '{2'd3, 4'd0, 12'h0F0, 12'h666};
    tbl[7] = '{2'd0, 4'd0, 12'hA5C, 12'hA5C};
    tbl[8] = '{2'd2, 4'd0, 12'h000, 12'hFFF};
    tbl[9] = '{2'd3, 4'd9, 12'h000, 12'hFFF};

    reset_n = 1'b0;
    cfg_mode = 2'd0;
    cfg_thresh = 4'd0;
    s_valid = 1'b0;
    s_data = '0;
    s_user = '0;
    s_sof = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", DW'(m_valid), DW'(0));
    chk("rst_m_data", m_data, '0);
    chk("rst_m_user_sof", DW'({m_user, m_sof}), DW'(0));
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Vector table: one sof beat per entry, exact latency with m_ready high.
    chk_lat = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(rep(tbl[i].pix), UW'(i), 1'b1, tbl[i].mode, tbl[i].thresh);
      repeat (2) @(negedge clk);
      chk("tbl_valid", DW'(m_valid), DW'(1));
      chk("tbl_data", m_data, rep(tbl[i].exp));
      @(posedge clk);
      #1;
    end
    drain("tbl_drain");
    chk_lat = 1'b0;

    // Random stream under random backpressure.
    base = ndeliv;
    rand_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < PIX; k++) d[k*PW +: PW] = 12'($urandom_range(0, 4095));
      send(d, UW'(i), (i % 7) == 0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
    end
    drain("stream_drain");
    rand_ready = 1'b0;
    ready_fix = 1'b1;
    chk("stream_count", DW'(ndeliv - base), DW'(20));
    @(posedge clk);
    #1;

    // Mid-frame cfg change takes effect only at the next sof.
    out_log.delete();
    send(rep(12'hF00), 3'd0, 1'b1, 2'd1, 4'd0);
    send(rep(12'hF00), 3'd1, 1'b0, 2'd2, 4'd6);
    send(rep(12'h0F0), 3'd2, 1'b0, 2'd2, 4'd6);
    send(rep(12'h0F0), 3'd3, 1'b1, 2'd2, 4'd6);
    send(rep(12'hF00), 3'd4, 1'b0, 2'd2, 4'd6);
    drain("mid_drain");
    ex = '{12'h555, 12'h555, 12'h999, 12'hFFF, 12'h000, 12'h0, 12'h0, 12'h0};
    check_log("midframe", ex, 5);

    // Back-to-back sof beats each re-latch the config.
    out_log.delete();
    send(rep(12'h0F0), 3'd5, 1'b1, 2'd3, 4'd0);
    send(rep(12'hA5C), 3'd6, 1'b1, 2'd0, 4'd0);
    send(rep(12'h000), 3'd7, 1'b1, 2'd2, 4'd0);
    send(rep(12'h000), 3'd0, 1'b0, 2'd1, 4'd5);
    drain("sof_drain");
    ex = '{12'h666, 12'hA5C, 12'hFFF, 12'hFFF, 12'h0, 12'h0, 12'h0, 12'h0};
    check_log("sof_relatch", ex, 4);

    // Fill under stall, then reset with two beats in flight.
    ready_fix = 1'b0;
    @(posedge clk);
    #1;
    send(rep(12'h0F0), 3'd1, 1'b1, 2'd3, 4'd0);
    send(rep(12'hF00), 3'd2, 1'b0, 2'd3, 4'd0);
    @(negedge clk);
    chk("full_stall_ready", DW'(s_ready), DW'(0));
    chk("full_stall_valid", DW'(m_valid), DW'(1));
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", DW'(m_valid), DW'(0));
    chk("async_rst_data", m_data, '0);
    repeat (2) @(posedge clk);
    #1;
    ready_fix = 1'b1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    out_log.delete();
    send(rep(12'hF00), 3'd3, 1'b0, 2'd3, 4'd0);
    drain("post_rst_drain");
    ex = '{12'h555, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0};
    check_log("post_rst_gray", ex, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
